touch_uart_decoder: RTL

//  Decodes the 5-byte AR1100 touchscreen packet stream that arrives on the touch UART pin
//  (GPIO_0[31]) into registered X/Y/pen coordinates.

---
 rtl/touch_pkg.sv | 15 +
 rtl/touch_uart_decoder_if.sv | 20 ++
 rtl/uart_rx_byte.sv | 131 +++++++++++++
 rtl/touch_uart_decoder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/touch_pkg.sv
// Shared types and constants for the touch UART decoder.
//   rx_state_t  : byte receiver states
//   pkt_state_t : packet assembler states
//   HDR_BIT     : bit that marks a header byte
//   COORD_W     : coordinate width
package touch_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  typedef enum logic [2:0] {WAIT_HDR, X_LO, X_HI, Y_LO, Y_HI} pkt_state_t;

  localparam int HDR_BIT = 7;
  localparam int COORD_W = 12;

endpackage

// File: rtl/touch_uart_decoder_if.sv
// Decoded touch output bundle.
//   touch_valid : one-cycle pulse, new coordinates present
//   touch_pen   : 1 = pen down
//   touch_x/y   : coordinates, 0..4095
//   frame_err   : one-cycle pulse, stop bit low, byte dropped
//   sync_err    : one-cycle pulse, data byte while waiting for a header
// master = decoder (drives), slave = consumer.
interface touch_uart_decoder_if;
  import touch_pkg::*;

  logic               touch_valid;
  logic               touch_pen;
  logic [COORD_W-1:0] touch_x;
  logic [COORD_W-1:0] touch_y;
  logic               frame_err;
  logic               sync_err;

  modport master (output touch_valid, touch_pen, touch_x, touch_y, frame_err, sync_err);
  modport slave  (input  touch_valid, touch_pen, touch_x, touch_y, frame_err, sync_err);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with 2-FF synchroniser and oversampling tick generator.
//   clk, reset_n : system clock, async active-low reset
//   rxd          : raw serial line, idle high
//   byte_data    : last received byte (valid with byte_valid)
//   byte_valid   : one-cycle pulse, good stop bit
//   frame_err    : one-cycle pulse, stop bit low, byte dropped
//
// state | meaning
// IDLE  | line idle, tick counter free-running, waiting for falling edge
// START | counting half a bit to re-check the start bit mid-bit
// DATA  | sampling 8 data bits LSB first, one per OVERSAMPLE ticks
// STOP  | sampling stop bit, then report byte or framing error
module uart_rx_byte
  import touch_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t        state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             fall, tick;

  assign fall = rx_prev_q & ~rx_sync_q;
  assign tick = (div_cnt_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rxd;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
    os_cnt_d     = os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Re-phase the tick counter to the start edge so samples land mid-bit.
        if (fall) begin
          state_d   = START;
          div_cnt_d = '0;
          os_cnt_d  = '0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
            os_cnt_d = '0;
            state_d  = rx_sync_q ? IDLE : DATA;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
            os_cnt_d  = '0;
            shift_d   = {rx_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_d = STOP;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
            os_cnt_d     = '0;
            byte_valid_d = rx_sync_q;
            frame_err_d  = ~rx_sync_q;
            state_d      = IDLE;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data  = shift_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/touch_uart_decoder.sv
// AR1100 5-byte touch packet decoder: UART receive plus packet assembly.
//   clk, reset_n : system clock, async active-low reset
//   rxd          : raw touch UART line, idle high
//   tif          : decoded outputs (touch_valid/pen/x/y, frame_err, sync_err)
//
// state    | meaning
// WAIT_HDR | waiting for header byte (bit7 = 1)
// X_LO     | expecting x[6:0]
// X_HI     | expecting x[11:7]
// Y_LO     | expecting y[6:0]
// Y_HI     | expecting y[11:7], then publish packet
module touch_uart_decoder
  import touch_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rxd,
  touch_uart_decoder_if.master  tif
);

  logic [7:0]         byte_data;
  logic               byte_valid;
  logic               frame_err;

  pkt_state_t         pkt_q, pkt_d;
  logic               pen_q, pen_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [6:0]         y_lo_q, y_lo_d;
  logic               out_pen_q, out_pen_d;
  logic [COORD_W-1:0] out_x_q, out_x_d;
  logic [COORD_W-1:0] out_y_q, out_y_d;
  logic               valid_q, valid_d;
  logic               sync_err_q, sync_err_d;

  uart_rx_byte #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxd       (rxd),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q      <= WAIT_HDR;
      pen_q      <= 1'b0;
      x_q        <= '0;
      y_lo_q     <= '0;
      out_pen_q  <= 1'b0;
      out_x_q    <= '0;
      out_y_q    <= '0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      pkt_q      <= pkt_d;
      pen_q      <= pen_d;
      x_q        <= x_d;
      y_lo_q     <= y_lo_d;
      out_pen_q  <= out_pen_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Partial packet lives in pen_q/x_q/y_lo_q; outputs only change on the final byte.
  always_comb begin
    pkt_d      = pkt_q;
    pen_d      = pen_q;
    x_d        = x_q;
    y_lo_d     = y_lo_q;
    out_pen_d  = out_pen_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;
    if (byte_valid) begin
      if (byte_data[HDR_BIT]) begin
        // A header restarts assembly from any state.
        pen_d = byte_data[0];
        pkt_d = X_LO;
      end else begin
        case (pkt_q)
          WAIT_HDR: sync_err_d = 1'b1;
          X_LO: begin
            x_d[6:0] = byte_data[6:0];
            pkt_d    = X_HI;
          end
          X_HI: begin
            x_d[11:7] = byte_data[4:0];
            pkt_d     = Y_LO;
          end
          Y_LO: begin
            y_lo_d = byte_data[6:0];
            pkt_d  = Y_HI;
          end
          Y_HI: begin
            out_pen_d = pen_q;
            out_x_d   = x_q;
            out_y_d   = {byte_data[4:0], y_lo_q};
            valid_d   = 1'b1;
            pkt_d     = WAIT_HDR;
          end
          default: pkt_d = WAIT_HDR;
        endcase
      end
    end
  end

  assign tif.touch_valid = valid_q;
  assign tif.touch_pen   = out_pen_q;
  assign tif.touch_x     = out_x_q;
  assign tif.touch_y     = out_y_q;
  assign tif.frame_err   = frame_err;
  assign tif.sync_err    = sync_err_q;

endmodule
